// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator owning the column/row counters,
// sync/enable decode, start-of-frame and line-match pulses and a frame counter.
// All outputs are registered and decoded from next-state counter values, so
// syncs and enables always describe the (column,row) presented in that cycle.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CNT_W     = 11,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_en,
    input  logic [CNT_W-1:0]   match_row,
    output logic [CNT_W-1:0]   column,
    output logic [CNT_W-1:0]   row,
    output logic               hsync,
    output logic               vsync,
    output logic               rgb_en,
    output logic               sof,
    output logic               line_match,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CNT_W-1:0]   column_q, column_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               rgb_en_q, rgb_en_d;
    logic               sof_q, sof_d;
    logic               line_match_q, line_match_d;

    // Next-state counters and decode of outputs from the next (column,row)
    always_comb begin
        column_d     = column_q;
        row_d        = row_q;
        frame_d      = frame_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        rgb_en_d     = rgb_en_q;
        sof_d        = 1'b0;
        line_match_d = 1'b0;
        if (pix_en) begin
            if (column_q == CNT_W'(H_TOTAL - 1)) begin
                column_d = '0;
                if (row_q == CNT_W'(V_TOTAL - 1)) begin
                    row_d   = '0;
                    frame_d = frame_q + FRAME_W'(1);
                    sof_d   = 1'b1;
                end else begin
                    row_d = row_q + CNT_W'(1);
                end
                line_match_d = (row_d == match_row);
            end else begin
                column_d = column_q + CNT_W'(1);
            end
            hsync_d  = ((column_d >= CNT_W'(HS_START)) && (column_d < CNT_W'(HS_END)))
                       ? HSYNC_POL : ~HSYNC_POL;
            vsync_d  = ((row_d >= CNT_W'(VS_START)) && (row_d < CNT_W'(VS_END)))
                       ? VSYNC_POL : ~VSYNC_POL;
            rgb_en_d = (column_d < CNT_W'(H_ACTIVE)) && (row_d < CNT_W'(V_ACTIVE));
        end
    end

    // State registers; reset lands on (0,0) without raising sof
    always_ff @(posedge clk) begin
        if (rst) begin
            column_q     <= '0;
            row_q        <= '0;
            frame_q      <= '0;
            hsync_q      <= ~HSYNC_POL;
            vsync_q      <= ~VSYNC_POL;
            rgb_en_q     <= 1'b1;
            sof_q        <= 1'b0;
            line_match_q <= 1'b0;
        end else begin
            column_q     <= column_d;
            row_q        <= row_d;
            frame_q      <= frame_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            rgb_en_q     <= rgb_en_d;
            sof_q        <= sof_d;
            line_match_q <= line_match_d;
        end
    end

    assign column     = column_q;
    assign row        = row_q;
    assign frame_cnt  = frame_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign rgb_en     = rgb_en_q;
    assign sof        = sof_q;
    assign line_match = line_match_q;

endmodule
